// File: rtl/seq_bitscan_alu.sv
// rtl/seq_bitscan_alu.sv - multi-cycle E-stage ALU: 1-cycle ADD/SUB/OR/AND, chunked bit-scan CMCO/CMCZ/POPC
// Optional SEQ_BITSCAN_ALU_OVF_EN adds a registered signed-overflow flag for ADD/SUB.
module seq_bitscan_alu #(
  parameter int WIDTH     = 32,
  parameter int SCAN_STEP = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       ALUop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] AO
`ifdef SEQ_BITSCAN_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int K  = WIDTH / SCAN_STEP;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_CMCO = 4'd4;
  localparam logic [3:0] OP_CMCZ = 4'd5;
  localparam logic [3:0] OP_POPC = 4'd6;

  generate
    if ((WIDTH % SCAN_STEP) != 0 || WIDTH < 8) begin : g_param_check
      $error("seq_bitscan_alu: SCAN_STEP must divide WIDTH and WIDTH must be >= 8");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    run_q, run_d;
  logic [CW-1:0]    best_q, best_d;
  logic [WIDTH-1:0] scan_q, scan_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] ao_q, ao_d;

  logic [WIDTH-1:0] alu_res;
  logic             is_scan_op;
  logic [CW-1:0]    run_v, best_v;
  logic             bit_v;

  always_comb begin
    alu_res = '0;
    case (ALUop)
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_OR:   alu_res = A | B;
      OP_AND:  alu_res = A & B;
      default: alu_res = '0;
    endcase
    is_scan_op = (ALUop == OP_CMCO) || (ALUop == OP_CMCZ) || (ALUop == OP_POPC);
  end

`ifdef SEQ_BITSCAN_ALU_OVF_EN
  logic ovf_q, ovf_d, alu_ovf;
  always_comb begin
    alu_ovf = 1'b0;
    if (ALUop == OP_ADD)
      alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
    else if (ALUop == OP_SUB)
      alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
  end
  assign ovf = ovf_q;
`endif

  // One chunk per cycle; run_v carries in from the previous chunk so runs span chunk borders.
  always_comb begin
    run_v  = run_q;
    best_v = best_q;
    bit_v  = 1'b0;
    for (int i = 0; i < SCAN_STEP; i++) begin
      bit_v = (op_q == OP_CMCZ) ? ~scan_q[i] : scan_q[i];
      if (op_q == OP_POPC) begin
        if (bit_v) best_v = best_v + CW'(1);
      end else begin
        run_v = bit_v ? run_v + CW'(1) : '0;
        if (run_v > best_v) best_v = run_v;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    run_d   = run_q;
    best_d  = best_q;
    scan_d  = scan_q;
    op_d    = op_q;
    ao_d    = ao_q;
`ifdef SEQ_BITSCAN_ALU_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_SCAN: begin
          run_d  = run_v;
          best_d = best_v;
          scan_d = scan_q >> SCAN_STEP;
          idx_d  = idx_q + IW'(1);
          if (idx_q == IW'(K - 1)) begin
            ao_d    = WIDTH'(best_v);
`ifdef SEQ_BITSCAN_ALU_OVF_EN
            ovf_d   = 1'b0;
`endif
            state_d = S_DONE;
          end
        end
        default: begin
          if (start) begin
            op_d = ALUop;
            if (is_scan_op) begin
              state_d = S_SCAN;
              idx_d   = '0;
              run_d   = '0;
              best_d  = '0;
              scan_d  = A;
            end else begin
              state_d = S_DONE;
              ao_d    = alu_res;
`ifdef SEQ_BITSCAN_ALU_OVF_EN
              ovf_d   = alu_ovf;
`endif
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      run_q   <= '0;
      best_q  <= '0;
      scan_q  <= '0;
      op_q    <= '0;
      ao_q    <= '0;
`ifdef SEQ_BITSCAN_ALU_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      best_q  <= best_d;
      scan_q  <= scan_d;
      op_q    <= op_d;
      ao_q    <= ao_d;
`ifdef SEQ_BITSCAN_ALU_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_SCAN);
  assign done = (state_q == S_DONE);
  assign AO   = ao_q;

endmodule

// File: tb/tb_seq_bitscan_alu.sv
// tb/tb_seq_bitscan_alu.sv - self-checking bench for seq_bitscan_alu (table, corner sequences, random vs model)
module tb_seq_bitscan_alu;
  localparam int W = 32;
  localparam int K = 8;

  logic         clk = 1'b0;
  logic         reset_n, start, flush;
  logic [3:0]   ALUop;
  logic [W-1:0] A, B;
  logic         busy, done;
  logic [W-1:0] AO;
`ifdef SEQ_BITSCAN_ALU_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_bitscan_alu #(.WIDTH(W), .SCAN_STEP(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ALUop(ALUop), .A(A), .B(B),
    .flush(flush), .busy(busy), .done(done), .AO(AO)
`ifdef SEQ_BITSCAN_ALU_OVF_EN
    , .ovf(ovf)
`endif
  );

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Longest run of ones found by testing every window width and position.
  function automatic int max_run(input logic [W-1:0] x);
    logic [63:0] m;
    int best;
    best = 0;
    for (int len = 1; len <= W; len++) begin
      m = (64'd1 << len) - 64'd1;
      for (int s = 0; s + len <= W; s++)
        if ((({32'b0, x} >> s) & m) == m) best = len;
    end
    return best;
  endfunction

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a | b;
      4'd3:    return a & b;
      4'd4:    return W'(max_run(a));
      4'd5:    return W'(max_run(~a));
      4'd6:    return W'($countones(a));
      default: return '0;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint s;
    if (op == 4'd0)      s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 4'd1) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Issue one op, scramble inputs after acceptance, then wait (bounded) for done.
  task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_ao, input logic exp_ovf);
    int lat, busy_cnt, exp_lat;
    bit scan;
    scan    = (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
    exp_lat = scan ? K + 1 : 1;
    start = 1'b1; ALUop = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; ALUop = 4'($urandom);
    lat = 1; busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, W'(lat), W'(exp_lat));
    chk({name, " busy_cycles"}, W'(busy_cnt), scan ? W'(K) : W'(0));
    chk({name, " AO"}, AO, exp_ao);
`ifdef SEQ_BITSCAN_ALU_OVF_EN
    chk({name, " ovf"}, W'(ovf), W'(exp_ovf));
`endif
  endtask

  initial begin
    int lat;
    bit seen;
    logic [3:0] op;
    logic [W-1:0] a, b;

    vecs[0]  = '{"add_ovf",   4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    vecs[1]  = '{"sub_neg",   4'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{"add_wrap",  4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[3]  = '{"sub_ovf",   4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    vecs[4]  = '{"or",        4'd2,  32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0};
    vecs[5]  = '{"and",       4'd3,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
    vecs[6]  = '{"reserved",  4'd9,  32'h00000001, 32'h00000002, 32'h00000000, 1'b0};
    vecs[7]  = '{"cmco_mix",  4'd4,  32'h00FF0F00, 32'h12345678, 32'd8,        1'b0};
    vecs[8]  = '{"cmco_span", 4'd4,  32'h00000FF0, 32'h0,        32'd8,        1'b0};
    vecs[9]  = '{"cmco_all",  4'd4,  32'hFFFFFFFF, 32'h0,        32'd32,       1'b0};
    vecs[10] = '{"cmcz_ones", 4'd5,  32'hFFFFFFFF, 32'h0,        32'd0,        1'b0};
    vecs[11] = '{"cmcz_all",  4'd5,  32'h00000000, 32'h0,        32'd32,       1'b0};
    vecs[12] = '{"cmcz_mid",  4'd5,  32'hF0000001, 32'h0,        32'd27,       1'b0};
    vecs[13] = '{"popc",      4'd6,  32'hF0F0F0F0, 32'h0,        32'd16,       1'b0};

    reset_n = 1'b0; start = 1'b0; flush = 1'b0; ALUop = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", W'(busy), '0);
    chk("reset done", W'(done), '0);
    chk("reset AO", AO, '0);
`ifdef SEQ_BITSCAN_ALU_OVF_EN
    chk("reset ovf", W'(ovf), '0);
`endif
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].exp_ovf);

    // Start during SCAN is ignored; AO holds the previous result (16) while scanning.
    start = 1'b1; ALUop = 4'd4; A = 32'h0000000F; B = '0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 2) begin start = 1'b1; ALUop = 4'd0; A = 32'd1; B = 32'd1; end
      if (lat == 3) chk("ao_hold_scan", AO, 32'd16);
      if (lat == 4) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("ignore_start latency", W'(lat), W'(K + 1));
    chk("ignore_start AO", AO, 32'd4);
    // Back-to-back accept in the DONE cycle.
    start = 1'b1; ALUop = 4'd2; A = 32'h0F; B = 32'hF0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b done", W'(done), 32'd1);
    chk("b2b AO", AO, 32'hFF);
    @(posedge clk); #1;
    chk("b2b done_pulse", W'(done), '0);

    // Flush at scan cycle 3.
    start = 1'b1; ALUop = 4'd4; A = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", W'(busy), '0);
    chk("flush done", W'(done), '0);
    chk("flush AO", AO, 32'hFF);
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    chk("flush no_late_done", W'(seen), '0);
    // Flush beats a simultaneous start.
    start = 1'b1; flush = 1'b1; ALUop = 4'd0; A = 32'd1; B = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start done", W'(done), '0);
    chk("flush_start busy", W'(busy), '0);
    @(posedge clk); #1;
    chk("flush_start done2", W'(done), '0);
    chk("flush_start AO", AO, 32'hFF);

    // Asynchronous reset mid-scan.
    start = 1'b1; ALUop = 4'd4; A = 32'h0000FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst busy", W'(busy), '0);
    chk("async_rst done", W'(done), '0);
    chk("async_rst AO", AO, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_op("post_rst cmco", 4'd4, 32'h00FF0F00, 32'h0, 32'd8, 1'b0);

    // Random ops against the reference model.
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) op = 4'($urandom_range(4, 6));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 3))
        0: a = a & $urandom & $urandom;
        1: a = a | $urandom | $urandom;
        2: a = (32'hFFFFFFFF >> $urandom_range(0, 31)) << $urandom_range(0, 31);
        default: ;
      endcase
      run_op($sformatf("rand%0d op%0d", n, op), op, a, b, model(op, a, b), model_ovf(op, a, b));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
